vijayank88_arbiter_puf: RTL and testbench

//  Synthesizable emulation of an 8-stage arbiter PUF for a TinyTapeout tile.
//  An 8-bit challenge on ui_in sets the switch stages; the response bit is which path wins the race.

---
 rtl/vijayank88_puf_pkg.sv | 19 +
 rtl/vijayank88_arbiter_puf_if.sv | 30 +++
 rtl/vijayank88_puf_stage.sv | 29 ++
 rtl/vijayank88_arbiter_puf.sv | 106 ++++++++++
 tb/tb_vijayank88_arbiter_puf.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/vijayank88_puf_pkg.sv
// Shared types and constants for the 8-stage arbiter PUF tile.
// Holds the FSM state enum, stage count and default delay tables.
package vijayank88_puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    localparam int NSTAGES = 8;

    // One nibble per stage, stage i at [4i+3:4i].
    localparam logic [31:0] P_DLY_DEF = 32'h5555_5555;
    localparam logic [31:0] Q_DLY_DEF = 32'h4444_4444;
    localparam logic [31:0] R_DLY_DEF = 32'h6666_6666;
    localparam logic [31:0] S_DLY_DEF = 32'h3333_3333;

endpackage

// File: rtl/vijayank88_arbiter_puf_if.sv
// TinyTapeout tile pin bundle for the arbiter PUF.
// master: harness side (drives ui_in/uio_in/ena); slave: tile side.
interface vijayank88_arbiter_puf_if;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/vijayank88_puf_stage.sv
// One arbiter switch stage: combinational update of the path difference.
// Ports: delta_i/delta_o (top-bottom arrival, wraps), cross_i, p/q/r/s delays.
module vijayank88_puf_stage #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] delta_i,
    input  logic          cross_i,
    input  logic [3:0]    p_i,
    input  logic [3:0]    q_i,
    input  logic [3:0]    r_i,
    input  logic [3:0]    s_i,
    output logic [DW-1:0] delta_o
);

    logic [DW-1:0] p_w;
    logic [DW-1:0] q_w;
    logic [DW-1:0] r_w;
    logic [DW-1:0] s_w;

    assign p_w = {{(DW-4){1'b0}}, p_i};
    assign q_w = {{(DW-4){1'b0}}, q_i};
    assign r_w = {{(DW-4){1'b0}}, r_i};
    assign s_w = {{(DW-4){1'b0}}, s_i};

    // Crossing swaps the paths, so the running difference flips sign.
    assign delta_o = cross_i ? (r_w - s_w - delta_i)
                             : (delta_i + p_w - q_w);

endmodule

// File: rtl/vijayank88_arbiter_puf.sv
// Arbiter PUF tile: start on uio_in[0] races ui_in challenge, 1 stage/clk.
// uo_out = {delta[4:0] or 0 (DELTA_OUT_EN), busy, valid, response}.
module vijayank88_arbiter_puf
    import vijayank88_puf_pkg::*;
#(
    parameter int          DW    = 8,
    parameter logic [31:0] P_DLY = P_DLY_DEF,
    parameter logic [31:0] Q_DLY = Q_DLY_DEF,
    parameter logic [31:0] R_DLY = R_DLY_DEF,
    parameter logic [31:0] S_DLY = S_DLY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    state_t        state_q, state_d;
    logic [DW-1:0] delta_q, delta_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    chal_q, chal_d;
    logic          resp_q, resp_d;
    logic [DW-1:0] delta_nx;
    logic [4:0]    nib;
    logic          start;
    logic          unused_ok;

    assign start     = uio_in[0];
    assign nib       = {idx_q, 2'b00};
    assign unused_ok = &{1'b0, uio_in[7:1]};

    vijayank88_puf_stage #(.DW(DW)) u_stage (
        .delta_i (delta_q),
        .cross_i (chal_q[idx_q]),
        .p_i     (P_DLY[nib +: 4]),
        .q_i     (Q_DLY[nib +: 4]),
        .r_i     (R_DLY[nib +: 4]),
        .s_i     (S_DLY[nib +: 4]),
        .delta_o (delta_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            delta_q <= '0;
            idx_q   <= '0;
            chal_q  <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            delta_q <= delta_d;
            idx_q   <= idx_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        delta_d = delta_q;
        idx_d   = idx_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        unique case (state_q)
            IDLE: begin
                if (start && ena) begin
                    chal_d  = ui_in;
                    delta_d = '0;
                    idx_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                delta_d = delta_nx;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'(NSTAGES - 1)) begin
                    // Negative difference: top path arrived first.
                    resp_d  = delta_nx[DW-1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [4:0] dbg;
`ifdef DELTA_OUT_EN
    assign dbg = delta_q[4:0];
`else
    assign dbg = 5'b0;
`endif

    assign uo_out  = {dbg, (state_q == EVAL), (state_q == DONE), resp_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_vijayank88_arbiter_puf.sv
// Self-checking bench for the arbiter PUF tile.
// Random challenges compared against an integer race model.
module tb_vijayank88_arbiter_puf;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    vijayank88_arbiter_puf_if pins();

    vijayank88_arbiter_puf dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (pins.ui_in),
        .uo_out  (pins.uo_out),
        .uio_in  (pins.uio_in),
        .uio_out (pins.uio_out),
        .uio_oe  (pins.uio_oe),
        .ena     (pins.ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] PD = 32'h5555_5555;
    localparam logic [31:0] QD = 32'h4444_4444;
    localparam logic [31:0] RD = 32'h6666_6666;
    localparam logic [31:0] SD = 32'h3333_3333;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Final arrival difference as an 8-bit two's complement value.
    function automatic logic [7:0] model(input logic [7:0] ch);
        int d;
        int p, q, r, s;
        d = 0;
        for (int i = 0; i < 8; i++) begin
            p = int'((PD >> (4 * i)) & 32'hF);
            q = int'((QD >> (4 * i)) & 32'hF);
            r = int'((RD >> (4 * i)) & 32'hF);
            s = int'((SD >> (4 * i)) & 32'hF);
            if ((ch >> i) & 8'd1) d = -d + (r - s);
            else                  d = d + (p - q);
        end
        d = ((d % 256) + 256) % 256;
        return 8'(d);
    endfunction

    function automatic logic [4:0] dbg_exp(input logic [7:0] d);
`ifdef DELTA_OUT_EN
        return d[4:0];
`else
        return (d == 8'h00) ? 5'b0 : 5'b0;
`endif
    endfunction

    task automatic run(input logic [7:0] ch, input bit hold,
                       input bit scramble);
        logic [7:0] d;
        logic       r;
        d = model(ch);
        r = d[7];
        @(negedge clk);
        pins.ui_in  = ch;
        pins.uio_in = 8'h01;
        pins.ena    = 1'b1;
        @(negedge clk);
        chk("busy_e0", 32'(pins.uo_out[2]), 32'd1);
        if (!hold) pins.uio_in = 8'h00;
        if (scramble) begin
            pins.ui_in = 8'($urandom);
            pins.ena   = 1'($urandom);
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("eval_valid", 32'(pins.uo_out[1]), 32'd0);
            chk("eval_busy", 32'(pins.uo_out[2]), 32'd1);
        end
        @(negedge clk);
        chk("done_valid", 32'(pins.uo_out[1]), 32'd1);
        chk("done_busy", 32'(pins.uo_out[2]), 32'd0);
        chk("resp", 32'(pins.uo_out[0]), 32'(r));
        chk("delta_out", 32'(pins.uo_out[7:3]), 32'(dbg_exp(d)));
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("hold_valid", 32'(pins.uo_out[1]), 32'd1);
                chk("hold_busy", 32'(pins.uo_out[2]), 32'd0);
                chk("hold_resp", 32'(pins.uo_out[0]), 32'(r));
            end
            pins.uio_in = 8'h00;
        end
        @(negedge clk);
        chk("idle_valid", 32'(pins.uo_out[1]), 32'd0);
        chk("idle_busy", 32'(pins.uo_out[2]), 32'd0);
        chk("idle_resp", 32'(pins.uo_out[0]), 32'(r));
        pins.ena = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        pins.ui_in  = 8'h00;
        pins.uio_in = 8'h00;
        pins.ena    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_uo", 32'(pins.uo_out), 32'h00);
        chk("rst_oe", 32'(pins.uio_oe), 32'h00);
        chk("rst_uio", 32'(pins.uio_out), 32'h00);
        rst_n = 1'b1;

        chk("model_00", 32'(model(8'h00)), 32'h08);
        chk("model_80", 32'(model(8'h80)), 32'hFC);
        chk("model_FF", 32'(model(8'hFF)), 32'h00);
        chk("model_C0", 32'(model(8'hC0)), 32'h06);

        run(8'h00, 1'b0, 1'b0);
        run(8'h80, 1'b0, 1'b1);
        run(8'hFF, 1'b0, 1'b0);
        run(8'hC0, 1'b0, 1'b1);
        run(8'($urandom), 1'b1, 1'b1);

        // Enable low in IDLE: start must be ignored.
        @(negedge clk);
        pins.ena    = 1'b0;
        pins.uio_in = 8'h01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ena0_busy", 32'(pins.uo_out[2]), 32'd0);
            chk("ena0_valid", 32'(pins.uo_out[1]), 32'd0);
        end
        pins.uio_in = 8'h00;
        pins.ena    = 1'b1;

        for (int t = 0; t < 20; t++) begin
            run(8'($urandom), 1'($urandom), 1'b1);
        end

        // Reset in the middle of an evaluation.
        @(negedge clk);
        pins.ui_in  = 8'h5A;
        pins.uio_in = 8'h01;
        @(negedge clk);
        pins.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_uo", 32'(pins.uo_out), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_uo", 32'(pins.uo_out), 32'h00);

        run(8'h80, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
